ov7670_pixel_capture: RTL and testbench

Front-end capture stage feeding the orange classifier. Samples the OV7670 8-bit bus in RGB444 mode and assembles two bytes into one 12-bit pixel. Tracks column and row position, marks each pixel orange or not, and produces the per-pixel valid, row-active and frame-boundary signals the classifier consumes. Runs entirely in the camera PCLK domain, with clk driven by PCLK.

---
 rtl/ov7670_pixel_capture.sv | 241 ++++++++++++++++++++++++
 tb/tb_ov7670_pixel_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture
// ---------------------------------------------------------------------------
// Purpose: front-end capture for the orange classifier. Samples the OV7670
// 8-bit bus in RGB444 mode (two bytes per pixel) and assembles 12-bit pixels.
// It tracks column/row position, classifies each pixel as orange or not, and
// emits per-pixel valid, row-active and frame-boundary strobes. The whole
// block runs in the camera PCLK domain.
//
// Ports:
//   clk         camera PCLK; everything samples on the rising edge
//   rst_n       asynchronous active-low reset
//   vsync       camera VSYNC, high between frames
//   href        camera HREF, high during active row bytes
//   d[7:0]      camera data bus
//   test_mode   selects the synthetic test pattern (TEST_PATTERN_EN only)
//   red/green/blue[3:0]  assembled pixel nibbles
//   pixel_valid one-cycle strobe qualifying red/green/blue/is_orange/x/y
//   is_orange   orange classification of the strobed pixel
//   href_out    high from the first strobe of a row until the row ends
//   x[8:0]      column of the strobed pixel
//   y[7:0]      row of the strobed pixel
//   frame_done  one-cycle pulse when a non-empty frame ends
//
// Build option: define TEST_PATTERN_EN to add a vertical-stripe test pattern
// selected by test_mode. Without it test_mode is ignored.
// ---------------------------------------------------------------------------
module ov7670_pixel_capture #(
  parameter int         H_ACTIVE = 320,
  parameter int         V_ACTIVE = 240,
  parameter logic [3:0] R_MIN    = 4'd10,
  parameter logic [3:0] G_MIN    = 4'd3,
  parameter logic [3:0] G_MAX    = 4'd9,
  parameter logic [3:0] B_MAX    = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] d,
  input  logic       test_mode,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       pixel_valid,
  output logic       is_orange,
  output logic       href_out,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       frame_done
);

  localparam logic [1:0] WAIT_FRAME = 2'd0;
  localparam logic [1:0] WAIT_ROW   = 2'd1;
  localparam logic [1:0] BYTE_HI    = 2'd2;
  localparam logic [1:0] BYTE_LO    = 2'd3;

  localparam logic [8:0] H_LIM = 9'(H_ACTIVE);
  localparam logic [7:0] V_LIM = 8'(V_ACTIVE);

  // Input sync stage plus one more delay for edge detection
  logic       vsync_q, vsync_dly_q, href_q, href_dly_q;
  logic [7:0] d_q;

  logic [1:0] state_q, state_d;
  logic [8:0] col_q, col_d;
  logic [7:0] row_q, row_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic       orange_q, orange_d;
  logic       pv_q, pv_d;
  logic       href_out_q, href_out_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       fd_q, fd_d;
  logic       row_pix_q, row_pix_d;

  logic       vs_rise, vs_fall, hr_fall;
  logic [3:0] src_hi, src_g, src_b;

  assign vs_rise = vsync_q & ~vsync_dly_q;
  assign vs_fall = ~vsync_q & vsync_dly_q;
  assign hr_fall = ~href_q & href_dly_q;

`ifdef TEST_PATTERN_EN
  localparam logic [8:0] X_THIRD1 = 9'(H_ACTIVE / 3);
  localparam logic [8:0] X_THIRD2 = 9'((2 * H_ACTIVE) / 3);

  // Stripe pattern keyed on the current column replaces camera data so the
  // rest of the pipeline (timing, counters, classifier) is exercised as-is.
  always_comb begin
    src_hi = d_q[3:0];
    src_g  = d_q[7:4];
    src_b  = d_q[3:0];
    if (test_mode) begin
      if (col_q < X_THIRD1) begin
        src_hi = 4'hF; src_g = 4'h6; src_b = 4'h0;
      end else if (col_q < X_THIRD2) begin
        src_hi = 4'h0; src_g = 4'hF; src_b = 4'h0;
      end else begin
        src_hi = 4'h0; src_g = 4'h0; src_b = 4'hF;
      end
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign src_hi = d_q[3:0];
  assign src_g  = d_q[7:4];
  assign src_b  = d_q[3:0];
`endif

  // Capture FSM. A vsync rise outside WAIT_FRAME overrides everything,
  // including a simultaneous href fall.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    hi_d       = hi_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    orange_d   = orange_q;
    pv_d       = 1'b0;
    href_out_d = href_out_q;
    x_d        = x_q;
    y_d        = y_q;
    fd_d       = 1'b0;
    row_pix_d  = row_pix_q;

    if (state_q != WAIT_FRAME && vs_rise) begin
      fd_d       = (row_q != 8'd0) || row_pix_q;
      state_d    = WAIT_FRAME;
      col_d      = 9'd0;
      href_out_d = 1'b0;
      row_pix_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_FRAME: begin
          if (vs_fall) begin
            state_d   = WAIT_ROW;
            col_d     = 9'd0;
            row_d     = 8'd0;
            row_pix_d = 1'b0;
          end
        end
        WAIT_ROW: begin
          // First byte of a row is consumed on the same cycle href is seen
          if (href_q) begin
            hi_d    = src_hi;
            state_d = BYTE_LO;
          end
        end
        default: begin
          if (hr_fall) begin
            // Row end; any half-assembled pixel is simply dropped
            state_d    = WAIT_ROW;
            col_d      = 9'd0;
            row_d      = (row_q < V_LIM) ? row_q + 8'd1 : row_q;
            href_out_d = 1'b0;
            row_pix_d  = 1'b0;
          end else if (state_q == BYTE_HI) begin
            hi_d    = src_hi;
            state_d = BYTE_LO;
          end else begin
            if (col_q < H_LIM && row_q < V_LIM) begin
              pv_d       = 1'b1;
              red_d      = hi_q;
              green_d    = src_g;
              blue_d     = src_b;
              orange_d   = (hi_q >= R_MIN) && (src_g >= G_MIN) &&
                           (src_g <= G_MAX) && (src_b <= B_MAX) &&
                           (hi_q > src_g);
              x_d        = col_q;
              y_d        = row_q;
              href_out_d = 1'b1;
              row_pix_d  = 1'b1;
            end
            if (col_q < H_LIM) col_d = col_q + 9'd1;
            state_d = BYTE_HI;
          end
        end
      endcase
    end
  end

  // All state, including the input sync stage, clears asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      vsync_dly_q <= 1'b0;
      href_q      <= 1'b0;
      href_dly_q  <= 1'b0;
      d_q         <= 8'd0;
      state_q     <= WAIT_FRAME;
      col_q       <= 9'd0;
      row_q       <= 8'd0;
      hi_q        <= 4'd0;
      red_q       <= 4'd0;
      green_q     <= 4'd0;
      blue_q      <= 4'd0;
      orange_q    <= 1'b0;
      pv_q        <= 1'b0;
      href_out_q  <= 1'b0;
      x_q         <= 9'd0;
      y_q         <= 8'd0;
      fd_q        <= 1'b0;
      row_pix_q   <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      vsync_dly_q <= vsync_q;
      href_q      <= href;
      href_dly_q  <= href_q;
      d_q         <= d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hi_q        <= hi_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      orange_q    <= orange_d;
      pv_q        <= pv_d;
      href_out_q  <= href_out_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fd_q        <= fd_d;
      row_pix_q   <= row_pix_d;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign pixel_valid = pv_q;
  assign is_orange   = orange_q;
  assign href_out    = href_out_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Testbench for ov7670_pixel_capture: directed byte streams with
// hand-computed expected pixels, strobe counts and frame pulses.
module tb_ov7670_pixel_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] d = 8'd0;
  logic       test_mode = 1'b0;
  logic [3:0] red, green, blue;
  logic       pixel_valid, is_orange, href_out, frame_done;
  logic [8:0] x;
  logic [7:0] y;

  ov7670_pixel_capture dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
    .test_mode(test_mode), .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .is_orange(is_orange), .href_out(href_out),
    .x(x), .y(y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Strobe monitor, sampled 1 time unit after each rising edge
  int strobes, fdCycles, seqErr, orangeCnt, orangeLo, orangeHi, maxX, lastY;
  int expX, expY;
  bit trackSeq = 1'b0;

  always @(posedge clk) begin
    #1;
    if (frame_done) fdCycles++;
    if (pixel_valid) begin
      strobes++;
      if (is_orange) begin
        orangeCnt++;
        if (x < 9'd106) orangeLo++;
        else orangeHi++;
      end
      if (int'(x) > maxX) maxX = int'(x);
      lastY = int'(y);
      if (trackSeq) begin
        if (int'(x) != expX || int'(y) != expY) seqErr++;
        expX++;
        if (expX == 320) begin
          expX = 0;
          expY++;
        end
      end
    end
  end

  task automatic clearCounts();
    strobes = 0; fdCycles = 0; seqErr = 0; orangeCnt = 0;
    orangeLo = 0; orangeHi = 0; maxX = -1; lastY = -1;
  endtask

  // One PCLK cycle of camera bus activity, driven at the falling edge
  task automatic applyStimulus(input logic v, input logic h, input logic [7:0] b);
    @(negedge clk);
    vsync = v;
    href  = h;
    d     = b;
  endtask

  task automatic startFrame();
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic endFrame();
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic sendPixels(input int n, input logic [7:0] hiB, input logic [7:0] loB);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, hiB);
      applyStimulus(1'b0, 1'b1, loB);
    end
  endtask

  task automatic endRow();
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    clearCounts();
    repeat (2) @(negedge clk);
    checkOutput("reset_pixel_valid", int'(pixel_valid), 0);
    checkOutput("reset_rgb", int'({red, green, blue}), 0);
    checkOutput("reset_xy", int'({x, y}), 0);
    checkOutput("reset_flags", int'({is_orange, href_out, frame_done}), 0);
    rst_n = 1'b1;

    // vsync high/low out of WAIT_FRAME: no frame_done
    clearCounts();
    startFrame();
    checkOutput("no_fd_from_wait_frame", fdCycles, 0);

    // Row 0: pixels 0x0C58, 0x0F62, 0x0FF2, then a dangling byte
    clearCounts();
    applyStimulus(1'b0, 1'b1, 8'h0C);
    applyStimulus(1'b0, 1'b1, 8'h58);
    applyStimulus(1'b0, 1'b1, 8'h0F);
    checkOutput("latency_not_yet", int'(pixel_valid), 0);
    applyStimulus(1'b0, 1'b1, 8'h62);
    checkOutput("p0_valid", int'(pixel_valid), 1);
    checkOutput("p0_rgb", int'({red, green, blue}), 'hC58);
    checkOutput("p0_orange", int'(is_orange), 0);
    checkOutput("p0_x", int'(x), 0);
    checkOutput("p0_y", int'(y), 0);
    checkOutput("p0_href_out", int'(href_out), 1);
    applyStimulus(1'b0, 1'b1, 8'h0F);
    checkOutput("between_strobes", int'(pixel_valid), 0);
    applyStimulus(1'b0, 1'b1, 8'hF2);
    checkOutput("p1_rgb", int'({red, green, blue}), 'hF62);
    checkOutput("p1_orange", int'(is_orange), 1);
    checkOutput("p1_x", int'(x), 1);
    applyStimulus(1'b0, 1'b1, 8'h0A);
    checkOutput("p1_hold_x", int'(x), 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("p2_rgb", int'({red, green, blue}), 'hFF2);
    checkOutput("p2_orange", int'(is_orange), 0);
    checkOutput("p2_x", int'(x), 2);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("href_out_still_high", int'(href_out), 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("href_out_dropped", int'(href_out), 0);
    checkOutput("row0_strobes", strobes, 3);

    // Row 1: three bytes then href drops -> one pixel only
    clearCounts();
    applyStimulus(1'b0, 1'b1, 8'h0F);
    applyStimulus(1'b0, 1'b1, 8'h62);
    applyStimulus(1'b0, 1'b1, 8'h33);
    endRow();
    checkOutput("three_byte_strobes", strobes, 1);
    checkOutput("three_byte_y", lastY, 1);
    checkOutput("three_byte_x", maxX, 0);
    checkOutput("three_byte_rgb", int'({red, green, blue}), 'hF62);
    endFrame();
    checkOutput("frame1_done", fdCycles, 1);

    // Three rows of 330 pixels: 320 strobes each, then one frame_done
    startFrame();
    clearCounts();
    expX = 0;
    expY = 0;
    trackSeq = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sendPixels(330, 8'h0F, 8'h62);
      endRow();
    end
    endFrame();
    trackSeq = 1'b0;
    checkOutput("wide_strobes", strobes, 960);
    checkOutput("wide_max_x", maxX, 319);
    checkOutput("wide_last_y", lastY, 2);
    checkOutput("wide_xy_sequence", seqErr, 0);
    checkOutput("wide_orange", orangeCnt, 960);
    checkOutput("wide_frame_done", fdCycles, 1);

    // test_mode with non-orange camera data
    startFrame();
    clearCounts();
    test_mode = 1'b1;
    sendPixels(320, 8'h0C, 8'h58);
    endRow();
    test_mode = 1'b0;
    checkOutput("tp_strobes", strobes, 320);
`ifdef TEST_PATTERN_EN
    checkOutput("tp_orange_low", orangeLo, 106);
    checkOutput("tp_orange_high", orangeHi, 0);
    checkOutput("tp_last_rgb", int'({red, green, blue}), 'h00F);
`else
    checkOutput("tp_ignored_orange", orangeCnt, 0);
    checkOutput("tp_ignored_rgb", int'({red, green, blue}), 'hC58);
`endif
    endFrame();

    // Reset asserted for one cycle in the middle of a row
    startFrame();
    sendPixels(5, 8'h0F, 8'h62);
    applyStimulus(1'b0, 1'b1, 8'h0F);
    rst_n = 1'b0;
    #1;
    checkOutput("midrow_reset_valid", int'(pixel_valid), 0);
    checkOutput("midrow_reset_rgb", int'({red, green, blue}), 0);
    checkOutput("midrow_reset_x", int'(x), 0);
    checkOutput("midrow_reset_flags", int'({is_orange, href_out}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clearCounts();
    sendPixels(10, 8'h0F, 8'h62);
    endRow();
    endFrame();
    checkOutput("post_reset_no_strobe", strobes, 0);
    checkOutput("post_reset_no_fd", fdCycles, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    sendPixels(2, 8'h0F, 8'h62);
    endRow();
    checkOutput("post_reset_resume", strobes, 2);
    endFrame();
    checkOutput("post_reset_fd", fdCycles, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
